// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and pixel clamp for the convolution tap accumulator.
package conv_pkg;

    localparam int unsigned PP_W     = 12;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned HI_SHIFT = 4;
    localparam int unsigned PIX_W    = 8;

    // Working width for the clamp; wide enough for any sane accumulator width.
    localparam int unsigned CLAMP_W  = 64;

    typedef enum logic [0:0] {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } rx_state_e;

    // Arithmetic right shift, then saturate into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [CLAMP_W-1:0] value,
                                                   input int unsigned shift);
        logic signed [CLAMP_W-1:0] scaled;
        scaled = value >>> shift;
        if (scaled < 64'sd0) begin
            return '0;
        end else if (scaled > 64'sd255) begin
            return 8'hFF;
        end else begin
            return scaled[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pp_reassembler.sv
// Rebuilds signed 16-bit products from the multiplier's two-beat 12-bit partial stream
// and flags beat-sequence violations (sticky until reset).
module pp_reassembler
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PP_W-1:0]          p,
    input  logic                     out_st,
    input  logic                     cycle,
    input  logic                     clear,
    output logic signed [PROD_W-1:0] prod,
    output logic                     prod_valid,
    output logic                     proto_err
);

    rx_state_e                state_q, state_d;
    logic signed [PROD_W-1:0] lo_q, lo_d;
    logic                     err_q, err_d;
    logic signed [PROD_W-1:0] p_ext;
    logic                     beat0;
    logic                     beat1;

    assign p_ext = PROD_W'(signed'(p));
    // An X on cycle makes these conditions false, so it lands in the error paths.
    assign beat0 = out_st && (cycle == 1'b0);
    assign beat1 = !out_st && (cycle == 1'b1);

    // High beat carries bits [15:4]; the sum wraps mod 2^16 by construction.
    assign prod = lo_q + (p_ext << HI_SHIFT);

    // Next-state: beat acceptance, error detection; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        err_d      = err_q;
        prod_valid = 1'b0;
        if (clear) begin
            state_d = WAIT_LO;
        end else begin
            case (state_q)
                WAIT_LO: begin
                    if (beat0) begin
                        lo_d    = p_ext;
                        state_d = WAIT_HI;
                    end else if (out_st) begin
                        err_d = 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (beat1) begin
                        prod_valid = 1'b1;
                        state_d    = WAIT_LO;
                    end else begin
                        // Missing high beat: drop the low half, but a fresh beat 0 restarts.
                        err_d = 1'b1;
                        if (beat0) begin
                            lo_d    = p_ext;
                            state_d = WAIT_HI;
                        end else begin
                            lo_d    = '0;
                            state_d = WAIT_LO;
                        end
                    end
                end
                default: state_d = WAIT_LO;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LO;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign proto_err = err_q;

endmodule

// File: rtl/conv_tap_accumulator.sv
// Accumulates TAPS reassembled products into one convolution sum and emits the
// wide sum plus a scaled, clamped pixel with a one-cycle valid strobe.
module conv_tap_accumulator
    import conv_pkg::*;
#(
    parameter int unsigned TAPS  = 9,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PP_W-1:0]         p,
    input  logic                    out_st,
    input  logic                    cycle,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] sum,
    output logic [PIX_W-1:0]        pix,
    output logic                    sum_valid,
    output logic [7:0]              tap_cnt,
    output logic                    proto_err
);

    logic signed [PROD_W-1:0] prod;
    logic                     prod_valid;

    logic signed [ACC_W-1:0]  acc_q;
    logic [7:0]               tap_q;
    logic signed [ACC_W-1:0]  sum_q;
    logic [PIX_W-1:0]         pix_q;
    logic                     valid_q;

    logic signed [ACC_W-1:0]  acc_next;
    logic                     last_tap;

    pp_reassembler u_pp_reassembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .p          (p),
        .out_st     (out_st),
        .cycle      (cycle),
        .clear      (clear),
        .prod       (prod),
        .prod_valid (prod_valid),
        .proto_err  (proto_err)
    );

    assign acc_next = acc_q + ACC_W'(prod);
    assign last_tap = (tap_q == 8'(TAPS - 1));

    // Accumulate products; on the final tap publish the sum and restart the window
    // on the same edge so back-to-back windows need no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            tap_q   <= '0;
            sum_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                acc_q <= '0;
                tap_q <= '0;
            end else if (prod_valid) begin
                if (last_tap) begin
                    sum_q   <= acc_next;
                    pix_q   <= clamp_pix(CLAMP_W'(acc_next), SHIFT);
                    valid_q <= 1'b1;
                    acc_q   <= '0;
                    tap_q   <= '0;
                end else begin
                    acc_q <= acc_next;
                    tap_q <= tap_q + 8'd1;
                end
            end
        end
    end

    assign sum       = sum_q;
    assign pix       = pix_q;
    assign sum_valid = valid_q;
    assign tap_cnt   = tap_q;

endmodule
